frame_checker: RTL

//  Receive-side counterpart of frame_sender: consumes the gig_eth_mac RX client interface (rx_clk domain)
//  and parses test frames: DA(6) SA(6) EtherType(2) SEQ(4, big-endian) PAYLOAD(byte i = i[7:0]).

---
 rtl/frame_checker.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/frame_checker.sv
// ---------------------------------------------------------------------------
// frame_checker
//  Receive-side test-frame checker on the gig_eth_mac RX client interface.
//  The frame layout is DA(6) SA(6) EtherType(2) SEQ(4, big-endian) PAYLOAD,
//  where payload byte i carries i[7:0]. The block checks the EtherType, the
//  sequence continuity and the payload pattern. It pulses frame_caught for
//  each good test frame and keeps saturating good and error counters. FCS
//  bytes never appear on mac_rx_data.
//
//  Ports
//   rx_clk, reset           RX client clock; synchronous active-high reset
//   conf_rx_*               static MAC configuration (RX on, jumbo on,
//                           MAC checks the CRC)
//   mac_rx_data/dvld        frame bytes, dvld high and contiguous DA..payload
//   mac_rx_goodframe/bad    1-cycle status pulse, 1..8 cycles after last byte
//   frame_caught            1-cycle pulse: good test frame without errors
//   seq_err, pattern_err    1-cycle pulses issued together with the status
//   good_cnt, err_cnt       saturating frame counters
//   last_seq                SEQ of the last test frame that ended in goodframe
// ---------------------------------------------------------------------------
module frame_checker #(
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter int          CNT_W     = 16,
  parameter int          LEN_W     = 14
) (
  input  logic             rx_clk,
  input  logic             reset,
  output logic             conf_rx_en,
  output logic             conf_rx_jumbo_en,
  output logic             conf_rx_no_chk_crc,
  input  logic [7:0]       mac_rx_data,
  input  logic             mac_rx_dvld,
  input  logic             mac_rx_goodframe,
  input  logic             mac_rx_badframe,
  output logic             frame_caught,
  output logic             seq_err,
  output logic             pattern_err,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [31:0]      last_seq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_SEQ,
    S_PAYLOAD,
    S_WAIT_STAT,
    S_DROP,
    S_DROP_WAIT
  } state_t;

  assign conf_rx_en         = 1'b1;
  assign conf_rx_jumbo_en   = 1'b1;
  assign conf_rx_no_chk_crc = 1'b0;

  state_t           state;
  logic [LEN_W-1:0] byte_cnt;
  logic [31:0]      seq_reg;
  logic [31:0]      exp_seq;
  logic             seq_valid;
  logic             runt;
  logic             pat_bad;

  logic [LEN_W-1:0] byte_cnt_inc;
  logic [7:0]       exp_pay;
  logic             status;
  logic             good_stat;
  logic             in_frame;
  logic             end_eval;
  logic             end_runt;
  logic             seq_mis;
  logic             frame_err;
  logic             lost_stat;
  logic             start_frame;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // NOTE: every signal assigned here gets a value on every path; otherwise
  // the combinational block would infer latches.
  always_comb begin
    byte_cnt_inc = (byte_cnt == '1) ? byte_cnt : byte_cnt + LEN_W'(1);
    exp_pay      = 8'(byte_cnt - LEN_W'(18));
    status       = mac_rx_goodframe | mac_rx_badframe;
    good_stat    = mac_rx_goodframe & ~mac_rx_badframe;
    in_frame     = (state == S_HDR) || (state == S_SEQ) || (state == S_PAYLOAD);
    // Status may also coincide with the cycle in which dvld drops.
    end_eval     = status & ((state == S_WAIT_STAT) | (in_frame & ~mac_rx_dvld));
    end_runt     = (state == S_WAIT_STAT) ? runt : (state != S_PAYLOAD);
    seq_mis      = seq_valid & ~end_runt & (seq_reg != exp_seq);
    frame_err    = mac_rx_badframe | end_runt | pat_bad | seq_mis;
    // A new frame arriving before the status means the old status was lost.
    lost_stat    = (state == S_WAIT_STAT) & mac_rx_dvld & ~status;
    start_frame  = mac_rx_dvld &
                   ((state == S_IDLE) || (state == S_WAIT_STAT) || (state == S_DROP_WAIT));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge rx_clk) begin
    frame_caught <= 1'b0;
    seq_err      <= 1'b0;
    pattern_err  <= 1'b0;
    // NOTE: the reset is synchronous; it is evaluated only on the clock edge.
    if (reset) begin
      state     <= S_IDLE;
      byte_cnt  <= '0;
      seq_reg   <= '0;
      exp_seq   <= '0;
      seq_valid <= 1'b0;
      runt      <= 1'b0;
      pat_bad   <= 1'b0;
      good_cnt  <= '0;
      err_cnt   <= '0;
      last_seq  <= '0;
    end else begin
      if (end_eval) begin
        if (good_stat && !frame_err) begin
          frame_caught <= 1'b1;
          good_cnt     <= sat_inc(good_cnt);
        end else begin
          err_cnt <= sat_inc(err_cnt);
        end
        seq_err     <= seq_mis;
        pattern_err <= pat_bad & ~end_runt;
        if (good_stat && !end_runt) begin
          last_seq  <= seq_reg;
          exp_seq   <= seq_reg + 32'd1;
          seq_valid <= 1'b1;
        end
      end
      if (lost_stat) err_cnt <= sat_inc(err_cnt);

      if (start_frame) begin
        byte_cnt <= LEN_W'(1);
        runt     <= 1'b0;
        pat_bad  <= 1'b0;
        state    <= S_HDR;
      end else begin
        case (state)
          S_HDR: begin
            if (mac_rx_dvld) begin
              byte_cnt <= byte_cnt_inc;
              if (byte_cnt == LEN_W'(12) && mac_rx_data != ETHERTYPE[15:8])
                state <= S_DROP;
              else if (byte_cnt == LEN_W'(13))
                state <= (mac_rx_data == ETHERTYPE[7:0]) ? S_SEQ : S_DROP;
            end else begin
              runt  <= 1'b1;
              state <= end_eval ? S_IDLE : S_WAIT_STAT;
            end
          end
          S_SEQ: begin
            if (mac_rx_dvld) begin
              byte_cnt <= byte_cnt_inc;
              seq_reg  <= {seq_reg[23:0], mac_rx_data};
              if (byte_cnt == LEN_W'(17)) state <= S_PAYLOAD;
            end else begin
              runt  <= 1'b1;
              state <= end_eval ? S_IDLE : S_WAIT_STAT;
            end
          end
          S_PAYLOAD: begin
            if (mac_rx_dvld) begin
              byte_cnt <= byte_cnt_inc;
              // A saturated byte counter can no longer index the pattern.
              if (mac_rx_data != exp_pay || byte_cnt == '1) pat_bad <= 1'b1;
            end else begin
              state <= end_eval ? S_IDLE : S_WAIT_STAT;
            end
          end
          S_WAIT_STAT: begin
            if (status) state <= S_IDLE;
          end
          S_DROP: begin
            if (mac_rx_dvld) byte_cnt <= byte_cnt_inc;
            else             state    <= status ? S_IDLE : S_DROP_WAIT;
          end
          S_DROP_WAIT: begin
            if (status) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
